// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester A/B handshake and RAM bus bundle for ram_arbiter
// Ports (signals): req_x/lock_x/rw_x/ad_x/wd_x requests, ack_x/rd_x responses
// for x in {a,b}; ram_rw/ram_ad/ram_din to the RAM, ram_dout from the RAM.
// slave modport is the arbiter view, master modport is the requester/RAM view.
interface ram_arbiter_if;
    logic        req_a, lock_a, rw_a;
    logic [15:0] ad_a;
    logic [7:0]  wd_a;
    logic        ack_a;
    logic [7:0]  rd_a;
    logic        req_b, lock_b, rw_b;
    logic [15:0] ad_b;
    logic [7:0]  wd_b;
    logic        ack_b;
    logic [7:0]  rd_b;
    logic        ram_rw;
    logic [15:0] ram_ad;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    modport slave (
        input  req_a, lock_a, rw_a, ad_a, wd_a,
        output ack_a, rd_a,
        input  req_b, lock_b, rw_b, ad_b, wd_b,
        output ack_b, rd_b,
        output ram_rw, ram_ad, ram_din,
        input  ram_dout
    );

    modport master (
        output req_a, lock_a, rw_a, ad_a, wd_a,
        input  ack_a, rd_a,
        output req_b, lock_b, rw_b, ad_b, wd_b,
        input  ack_b, rd_b,
        input  ram_rw, ram_ad, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port (A = CPU, B = DMA) arbiter/sequencer for a single-port sync RAM
// Ports: clk, rst_n (async active-low), bus (ram_arbiter_if.slave: requests,
// acks/read data, RAM rw/ad/din outputs and registered ram_dout input).
// Each access runs IDLE -> ACCESS -> DONE; ack_x pulses in DONE with rd_x = ram_dout.
// Optional macro ARB_ROUND_ROBIN_EN: ties go to the requester not granted last
// (otherwise A always wins a tie). Lock behaviour is identical in both builds.
module ram_arbiter #(
    parameter int unsigned MAX_LOCK = 4
) (
    input logic         clk,
    input logic         rst_n,
    ram_arbiter_if.slave bus
);
    localparam logic [3:0] MAX_L = 4'(MAX_LOCK);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_n;
    logic        own_a, own_b, own_a_n, own_b_n;
    logic        lock_q, lock_q_n;
    logic [3:0]  cnt, cnt_n;
    logic        ram_rw_q, ram_rw_n;
    logic [15:0] ram_ad_q, ram_ad_n;
    logic [7:0]  ram_din_q, ram_din_n;
    logic        ack_a, ack_b, ack_a_n, ack_b_n;
    logic        req_own, relock, frel, tie_b, win_b;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_b, last_b_n;
    assign tie_b = ~last_b;
`else
    assign tie_b = 1'b0;
`endif

    assign req_own = (own_a & bus.req_a) | (own_b & bus.req_b);
    assign relock  = lock_q & req_own & (cnt < MAX_L);
    // Lock limit reached: the owner yields to the other side if it is waiting.
    assign frel    = lock_q & req_own & ~relock;
    assign win_b   = relock ? own_b :
                     frel   ? (own_b ? ~bus.req_a : bus.req_b) :
                              bus.req_b & (~bus.req_a | tie_b);

    always_comb begin
        state_n   = state;
        own_a_n   = own_a;
        own_b_n   = own_b;
        lock_q_n  = lock_q;
        cnt_n     = cnt;
        ram_rw_n  = ram_rw_q;
        ram_ad_n  = ram_ad_q;
        ram_din_n = ram_din_q;
        ack_a_n   = 1'b0;
        ack_b_n   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_b_n  = last_b;
`endif
        case (state)
            IDLE: begin
                lock_q_n = 1'b0;
                cnt_n    = relock ? cnt + 4'd1 : 4'd0;
                if (bus.req_a | bus.req_b) begin
                    state_n   = ACCESS;
                    own_a_n   = ~win_b;
                    own_b_n   = win_b;
                    ram_rw_n  = win_b ? bus.rw_b : bus.rw_a;
                    ram_ad_n  = win_b ? bus.ad_b : bus.ad_a;
                    ram_din_n = win_b ? bus.wd_b : bus.wd_a;
`ifdef ARB_ROUND_ROBIN_EN
                    last_b_n  = win_b;
`endif
                end
            end
            ACCESS: begin
                // RAM commits at this edge; drop RW so no second write happens.
                ram_rw_n = 1'b1;
                ack_a_n  = own_a;
                ack_b_n  = own_b;
                state_n  = DONE;
            end
            DONE: begin
                lock_q_n = own_b ? bus.lock_b : bus.lock_a;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            own_a     <= 1'b0;
            own_b     <= 1'b0;
            lock_q    <= 1'b0;
            cnt       <= 4'd0;
            ram_rw_q  <= 1'b1;
            ram_ad_q  <= 16'd0;
            ram_din_q <= 8'd0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_b    <= 1'b1;
`endif
        end else begin
            state     <= state_n;
            own_a     <= own_a_n;
            own_b     <= own_b_n;
            lock_q    <= lock_q_n;
            cnt       <= cnt_n;
            ram_rw_q  <= ram_rw_n;
            ram_ad_q  <= ram_ad_n;
            ram_din_q <= ram_din_n;
            ack_a     <= ack_a_n;
            ack_b     <= ack_b_n;
`ifdef ARB_ROUND_ROBIN_EN
            last_b    <= last_b_n;
`endif
        end
    end

    assign bus.ram_rw  = ram_rw_q;
    assign bus.ram_ad  = ram_ad_q;
    assign bus.ram_din = ram_din_q;
    assign bus.ack_a   = ack_a;
    assign bus.ack_b   = ack_b;
    assign bus.rd_a    = ack_a ? bus.ram_dout : 8'd0;
    assign bus.rd_b    = ack_b ? bus.ram_dout : 8'd0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a behavioural sync RAM
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_arbiter_if bus();
    ram_arbiter #(.MAX_LOCK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (!bus.ram_rw) mem[bus.ram_ad] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_ad];
    end

    int n_chk = 0, n_fail = 0;
    int wr_cyc = 0, ack_cyc = 0, both_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!bus.ram_rw) wr_cyc++;
        if (bus.ack_a | bus.ack_b) ack_cyc++;
        if (bus.ack_a & bus.ack_b) both_cyc++;
    endtask

    // who: 0 = A, 1 = B, 2 = both, -1 = none within the bound
    task automatic wait_ack(output int who, output int n);
        who = -1;
        n = 0;
        for (int i = 1; i <= 8 && who < 0; i++) begin
            tick();
            n = i;
            if (bus.ack_a | bus.ack_b) who = bus.ack_b ? (bus.ack_a ? 2 : 1) : 0;
        end
    endtask

    // lat counts the presenting IDLE cycle, ACCESS and DONE
    task automatic access(input bit pb, input bit rw, input logic [15:0] ad, input logic [7:0] wd,
                          output int who, output int lat, output logic [7:0] rd);
        if (pb) begin
            bus.req_b = 1'b1; bus.rw_b = rw; bus.ad_b = ad; bus.wd_b = wd;
        end else begin
            bus.req_a = 1'b1; bus.rw_a = rw; bus.ad_a = ad; bus.wd_a = wd;
        end
        wait_ack(who, lat);
        lat = lat + 1;
        rd = pb ? bus.rd_b : bus.rd_a;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        tick();
    endtask

    initial begin
        int who, lat, n, w0, a0, exp_b;
        logic [7:0] rd;
        rst_n = 1'b0;
        bus.req_a = 0; bus.lock_a = 0; bus.rw_a = 1; bus.ad_a = '0; bus.wd_a = '0;
        bus.req_b = 0; bus.lock_b = 0; bus.rw_b = 1; bus.ad_b = '0; bus.wd_b = '0;
        tick();
        tick();
        chk("rst_ram_rw", 32'(bus.ram_rw), 32'(1));
        chk("rst_ram_ad", 32'(bus.ram_ad), 32'(0));
        chk("rst_ram_din", 32'(bus.ram_din), 32'(0));
        chk("rst_ack_a", 32'(bus.ack_a), 32'(0));
        chk("rst_ack_b", 32'(bus.ack_b), 32'(0));
        chk("rst_rd_a", 32'(bus.rd_a), 32'(0));
        rst_n = 1'b1;
        tick();

        // single write of 0x5A to 0x0010 from A, cycle by cycle
        w0 = wr_cyc;
        bus.req_a = 1; bus.rw_a = 0; bus.ad_a = 16'h0010; bus.wd_a = 8'h5A;
        tick();
        chk("wr_access_rw", 32'(bus.ram_rw), 32'(0));
        chk("wr_access_ad", 32'(bus.ram_ad), 32'h0010);
        chk("wr_access_din", 32'(bus.ram_din), 32'h5A);
        chk("wr_access_ack", 32'(bus.ack_a), 32'(0));
        chk("wr_access_rd_a", 32'(bus.rd_a), 32'(0));
        tick();
        chk("wr_done_ack_a", 32'(bus.ack_a), 32'(1));
        chk("wr_done_rw", 32'(bus.ram_rw), 32'(1));
        chk("wr_done_ack_b", 32'(bus.ack_b), 32'(0));
        chk("wr_done_rd_b", 32'(bus.rd_b), 32'(0));
        bus.req_a = 0;
        tick();
        chk("wr_idle_ack_a", 32'(bus.ack_a), 32'(0));
        chk("wr_rw_low_cycles", 32'(wr_cyc - w0), 32'(1));

        access(0, 0, 16'h03FF, 8'hC3, who, lat, rd);
        chk("pre1_lat", 32'(lat), 32'(3));
        access(0, 0, 16'h0000, 8'h3C, who, lat, rd);
        access(0, 0, 16'h1234, 8'h77, who, lat, rd);

        access(0, 1, 16'h0010, 8'h00, who, lat, rd);
        chk("rd_a_who", 32'(who), 32'(0));
        chk("rd_a_lat", 32'(lat), 32'(3));
        chk("rd_a_data", 32'(rd), 32'h5A);

        // back-to-back B reads
        bus.req_b = 1; bus.rw_b = 1; bus.ad_b = 16'h03FF;
        wait_ack(who, n);
        chk("b2b_1_who", 32'(who), 32'(1));
        chk("b2b_1_rd", 32'(bus.rd_b), 32'hC3);
        bus.ad_b = 16'h0000;
        wait_ack(who, n);
        chk("b2b_2_who", 32'(who), 32'(1));
        chk("b2b_2_gap", 32'(n), 32'(3));
        chk("b2b_2_rd", 32'(bus.rd_b), 32'h3C);
        bus.req_b = 0;
        tick();

        // idle hold-off
        a0 = ack_cyc; w0 = wr_cyc;
        repeat (20) tick();
        chk("idle_acks", 32'(ack_cyc - a0), 32'(0));
        chk("idle_rw_low", 32'(wr_cyc - w0), 32'(0));
        chk("idle_ram_rw", 32'(bus.ram_rw), 32'(1));
        access(0, 1, 16'h1234, 8'h00, who, lat, rd);
        chk("idle_probe", 32'(rd), 32'h77);

        // tie: both read continuously; last grant so far was A
        bus.req_a = 1; bus.rw_a = 1; bus.ad_a = 16'h0010;
        bus.req_b = 1; bus.rw_b = 1; bus.ad_b = 16'h03FF;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_b = (k % 2 == 0) ? 1 : 0;
`else
            exp_b = 0;
`endif
            wait_ack(who, n);
            chk($sformatf("tie_%0d_who", k), 32'(who), 32'(exp_b));
            chk($sformatf("tie_%0d_rd", k), 32'(who == 1 ? bus.rd_b : bus.rd_a),
                32'(exp_b == 1 ? 8'hC3 : 8'h5A));
            if (k > 0) chk($sformatf("tie_%0d_gap", k), 32'(n), 32'(3));
        end
        bus.req_a = 0; bus.req_b = 0;
        tick();
        tick();
        chk("tie_no_double_ack", 32'(both_cyc), 32'(0));

        // lock limit: A,A,A,A,A,B,A
        bus.req_a = 1; bus.lock_a = 1; bus.rw_a = 1; bus.ad_a = 16'h0010;
        tick();
        bus.req_b = 1; bus.rw_b = 1; bus.ad_b = 16'h0000;
        for (int k = 0; k < 7; k++) begin
            wait_ack(who, n);
            chk($sformatf("lock_%0d_who", k), 32'(who), 32'(k == 5 ? 1 : 0));
        end
        bus.req_a = 0; bus.lock_a = 0; bus.req_b = 0;
        tick();
        tick();

        // reset during the ACCESS of a B write
        bus.req_b = 1; bus.rw_b = 0; bus.ad_b = 16'h0020; bus.wd_b = 8'hEE;
        tick();
        chk("rst_mid_rw_before", 32'(bus.ram_rw), 32'(0));
        a0 = ack_cyc;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rw", 32'(bus.ram_rw), 32'(1));
        chk("rst_mid_ad", 32'(bus.ram_ad), 32'(0));
        chk("rst_mid_ack_b", 32'(bus.ack_b), 32'(0));
        bus.req_b = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_mid_no_ack", 32'(ack_cyc - a0), 32'(0));
        access(0, 1, 16'h0010, 8'h00, who, lat, rd);
        chk("post_rst_who", 32'(who), 32'(0));
        chk("post_rst_lat", 32'(lat), 32'(3));
        chk("post_rst_rd", 32'(rd), 32'h5A);
        chk("final_no_double_ack", 32'(both_cyc), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
